ddr3_init_seq: RTL
==================

// Module: ddr3_init_seq
// PURPOSE
//  DDR3 power-up/initialisation sequencer that drives the DRAM command bus from reset to first usable state.
//  Sequence: RESET# hold, CKE-low wait, tXPR, then MRS to MR2/MR3/MR1/MR0 and ZQCL, repeated for each rank.
//  Timing and mode-register contents are parameters, so simulation can use short counts.
//  Sits between the clock/reset generator and the ddr3_controller command mux; owns the bus until init_done.
// PARAMETERS
//  ADDR_BITS  14     DRAM address width
//  BA_BITS    3      bank address width
//  RANKS      1      number of ranks (1..4); one cs_n bit each
//  T_RESET    40000  cycles RESET# held low after rst_n release (200us)
//  T_CKE      100000 cycles RESET# high before CKE rises (500us)
//  T_XPR      72     cycles CKE high before first MRS (tXPR)
//  T_MRD      4      cycles between MRS commands (>=2)
//  T_MOD      12     cycles after last MRS before ZQCL (>=2)
//  T_ZQINIT   512    cycles after ZQCL before next rank or done (>=2)
//  MR0..MR3   14'h0  mode-register values placed on addr during MRS
// PORTS
//  ck         in   1          controller clock (DRAM CK)
//  rst_n      in   1          async active-low reset
//  restart    in   1          one-cycle pulse; reruns the full sequence from RST_HOLD
//  ddr_rst_n  out  1          DRAM RESET#
//  cke        out  1          clock enable
//  cs_n       out  RANKS      per-rank chip select, active low
//  ras_n      out  1          command bit
//  cas_n      out  1          command bit
//  we_n       out  1          command bit
//  ba         out  BA_BITS    bank / MR select
//  addr       out  ADDR_BITS  address / MR value
//  odt        out  1          on-die termination; held 0 throughout
//  init_done  out  1          high once all ranks are initialised
// BEHAVIOUR
//  Reset (rst_n=0, async): state RST_HOLD, ddr_rst_n=0, cke=0, cs_n=all 1, ras_n=cas_n=we_n=1, ba=0, addr=0,
//   odt=0, init_done=0, rank=0, counter loaded with T_RESET-1.
//  All outputs are registered. Counter: each timed state loads N-1 on entry and advances when the count is 0 (exactly N cycles).
//  States:
//   RST_HOLD  ddr_rst_n=0, cke=0, deselect; T_RESET cycles -> CKE_WAIT
//   CKE_WAIT  ddr_rst_n=1, cke=0, deselect; T_CKE cycles -> XPR
//   XPR       cke=1, NOP to all ranks; T_XPR cycles -> MRS (idx=2)
//   MRS       one cycle; cs_n[rank]=0, others 1; ras/cas/we=000; ba=idx; addr=MRidx -> MWAIT
//   MWAIT     NOP; T_MRD-1 cycles; index order 2,3,1,0; after idx 0 use T_MOD-1 -> ZQCL
//   ZQCL      one cycle; cs_n[rank]=0; ras/cas/we=110; addr[10]=1, other addr=0, ba=0 -> ZWAIT
//   ZWAIT     NOP; T_ZQINIT-1 cycles; if rank<RANKS-1 then rank++ -> MRS(idx=2), else -> DONE
//   DONE      init_done=1, cke=1, ddr_rst_n=1, deselect (cs_n all 1, ras/cas/we=111); hold
//  Command spacing: MRS->MRS exactly T_MRD cycles; MRS0->ZQCL exactly T_MOD; ZQCL->next command exactly T_ZQINIT.
//  NOP encoding: cs_n[rank]=0, ras/cas/we=111, ba=0, addr=0. Deselect: cs_n all 1.
//  restart (any state, including mid-sequence): next cycle equals the reset state (init_done=0, rank=0).
//   restart in DONE has the same effect.
//  restart together with a timer expiry: restart wins.
//  The rank counter never wraps; RANKS=1 skips the increment path.
//  Counter width = $clog2(max timing parameter + 1).
// TESTING
//  (Bench params: T_RESET=8, T_CKE=10, T_XPR=5, T_MRD=4, T_MOD=12, T_ZQINIT=16, RANKS=2, MR0..MR3=14'h0520/0044/0018/0000.)
//  T1 Power-up: release rst_n -> ddr_rst_n=0 for 8 cycles, rises; cke rises 10 cycles later; first MRS 5 cycles after that.
//  T2 MRS order: rank 0 gets ba=2/addr=0018, ba=3/0000, ba=1/0044, ba=0/0520, each 4 cycles apart;
//     ZQCL (addr[10]=1) 12 cycles after MR0.
//  T3 Multi-rank: rank 0 sequence uses cs_n=2'b10; rank 1 sequence (cs_n=2'b01) starts 16 cycles after ZQCL0;
//     init_done rises 16 cycles after ZQCL1.
//  T4 Restart mid-MWAIT of rank 1 -> next cycle ddr_rst_n=0, cke=0, init_done=0; full sequence repeats starting at rank 0.
//  T5 Async reset asserted between clock edges during XPR -> outputs reach reset values immediately, without waiting for ck.
//  T6 Checker: odt=0 on every cycle; no command other than NOP/deselect while cke=0.

Source files
------------

// File: rtl/ddr3_init_seq.sv
// DDR3 power-up sequencer: RESET# hold, CKE wait, tXPR, MR2/MR3/MR1/MR0 + ZQCL per rank.
// Owns the DRAM command bus until init_done; all outputs come straight from registers.
module ddr3_init_seq #(
  parameter int ADDR_BITS = 14,
  parameter int BA_BITS   = 3,
  parameter int RANKS     = 1,
  parameter int T_RESET   = 40000,
  parameter int T_CKE     = 100000,
  parameter int T_XPR     = 72,
  parameter int T_MRD     = 4,
  parameter int T_MOD     = 12,
  parameter int T_ZQINIT  = 512,
  parameter logic [ADDR_BITS-1:0] MR0 = '0,
  parameter logic [ADDR_BITS-1:0] MR1 = '0,
  parameter logic [ADDR_BITS-1:0] MR2 = '0,
  parameter logic [ADDR_BITS-1:0] MR3 = '0
) (
  input  logic                 ck,
  input  logic                 rst_n,
  input  logic                 restart,
  output logic                 ddr_rst_n,
  output logic                 cke,
  output logic [RANKS-1:0]     cs_n,
  output logic                 ras_n,
  output logic                 cas_n,
  output logic                 we_n,
  output logic [BA_BITS-1:0]   ba,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 odt,
  output logic                 init_done
);

  localparam int M1    = (T_RESET > T_CKE) ? T_RESET : T_CKE;
  localparam int M2    = (T_XPR > T_MRD) ? T_XPR : T_MRD;
  localparam int M3    = (T_MOD > T_ZQINIT) ? T_MOD : T_ZQINIT;
  localparam int M4    = (M1 > M2) ? M1 : M2;
  localparam int T_MAX = (M4 > M3) ? M4 : M3;
  localparam int CW    = $clog2(T_MAX + 1);
  localparam int RW    = (RANKS > 1) ? $clog2(RANKS) : 1;
  localparam bit MULTI = (RANKS > 1);

  typedef enum logic [2:0] {
    RST_HOLD, CKE_WAIT, XPR, MRS, MWAIT, ZQCL, ZWAIT, DONE
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [RW-1:0]         r_rank;
  logic [1:0]            r_idx;
  logic                  r_ddr_rst_n, r_cke, r_init_done;
  logic [RANKS-1:0]      r_cs_n;
  logic                  r_ras_n, r_cas_n, r_we_n;
  logic [BA_BITS-1:0]    r_ba;
  logic [ADDR_BITS-1:0]  r_addr;
  logic                  w_expired;
  logic [1:0]            w_nxt_idx;

  assign w_expired = (r_cnt == '0);

  // Mode registers are programmed in the order 2, 3, 1, 0.
  always_comb begin
    w_nxt_idx = 2'd0;
    case (r_idx)
      2'd2:    w_nxt_idx = 2'd3;
      2'd3:    w_nxt_idx = 2'd1;
      default: w_nxt_idx = 2'd0;
    endcase
  end

  function automatic logic [ADDR_BITS-1:0] mr_val(input logic [1:0] i);
    case (i)
      2'd0:    mr_val = MR0;
      2'd1:    mr_val = MR1;
      2'd2:    mr_val = MR2;
      default: mr_val = MR3;
    endcase
  endfunction

  function automatic logic [RANKS-1:0] rank_sel(input logic [RW-1:0] r);
    rank_sel = ~(RANKS'(1) << r);
  endfunction

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RST_HOLD;
      r_cnt       <= CW'(T_RESET - 1);
      r_rank      <= '0;
      r_idx       <= 2'd2;
      r_ddr_rst_n <= 1'b0;
      r_cke       <= 1'b0;
      r_init_done <= 1'b0;
      r_cs_n      <= '1;
      r_ras_n     <= 1'b1;
      r_cas_n     <= 1'b1;
      r_we_n      <= 1'b1;
      r_ba        <= '0;
      r_addr      <= '0;
    end else if (restart) begin
      r_state     <= RST_HOLD;
      r_cnt       <= CW'(T_RESET - 1);
      r_rank      <= '0;
      r_idx       <= 2'd2;
      r_ddr_rst_n <= 1'b0;
      r_cke       <= 1'b0;
      r_init_done <= 1'b0;
      r_cs_n      <= '1;
      r_ras_n     <= 1'b1;
      r_cas_n     <= 1'b1;
      r_we_n      <= 1'b1;
      r_ba        <= '0;
      r_addr      <= '0;
    end else begin
      // Commands last one cycle; the bus falls back to NOP unless a state overrides it.
      r_ras_n <= 1'b1;
      r_cas_n <= 1'b1;
      r_we_n  <= 1'b1;
      r_ba    <= '0;
      r_addr  <= '0;
      if (!w_expired) r_cnt <= r_cnt - CW'(1);
      case (r_state)
        RST_HOLD: if (w_expired) begin
          r_state     <= CKE_WAIT;
          r_cnt       <= CW'(T_CKE - 1);
          r_ddr_rst_n <= 1'b1;
        end
        CKE_WAIT: if (w_expired) begin
          r_state <= XPR;
          r_cnt   <= CW'(T_XPR - 1);
          r_cke   <= 1'b1;
          r_cs_n  <= '0;
        end
        XPR: if (w_expired) begin
          r_state <= MRS;
          r_idx   <= 2'd2;
          r_cs_n  <= rank_sel(r_rank);
          r_ras_n <= 1'b0;
          r_cas_n <= 1'b0;
          r_we_n  <= 1'b0;
          r_ba    <= BA_BITS'(2);
          r_addr  <= MR2;
        end
        // Wait loads are N-2: the command cycle itself is the first of the N.
        MRS: begin
          r_state <= MWAIT;
          r_cnt   <= (r_idx == 2'd0) ? CW'(T_MOD - 2) : CW'(T_MRD - 2);
        end
        MWAIT: if (w_expired) begin
          if (r_idx == 2'd0) begin
            r_state <= ZQCL;
            r_we_n  <= 1'b0;
            r_addr  <= ADDR_BITS'(1024);
          end else begin
            r_state <= MRS;
            r_idx   <= w_nxt_idx;
            r_ras_n <= 1'b0;
            r_cas_n <= 1'b0;
            r_we_n  <= 1'b0;
            r_ba    <= BA_BITS'(w_nxt_idx);
            r_addr  <= mr_val(w_nxt_idx);
          end
        end
        ZQCL: begin
          r_state <= ZWAIT;
          r_cnt   <= CW'(T_ZQINIT - 2);
        end
        ZWAIT: if (w_expired) begin
          if (MULTI && r_rank != RW'(RANKS - 1)) begin
            r_state <= MRS;
            r_rank  <= r_rank + RW'(1);
            r_idx   <= 2'd2;
            r_cs_n  <= rank_sel(r_rank + RW'(1));
            r_ras_n <= 1'b0;
            r_cas_n <= 1'b0;
            r_we_n  <= 1'b0;
            r_ba    <= BA_BITS'(2);
            r_addr  <= MR2;
          end else begin
            r_state     <= DONE;
            r_init_done <= 1'b1;
            r_cs_n      <= '1;
          end
        end
        DONE: ;
        default: r_state <= RST_HOLD;
      endcase
    end
  end

  assign ddr_rst_n = r_ddr_rst_n;
  assign cke       = r_cke;
  assign cs_n      = r_cs_n;
  assign ras_n     = r_ras_n;
  assign cas_n     = r_cas_n;
  assign we_n      = r_we_n;
  assign ba        = r_ba;
  assign addr      = r_addr;
  assign odt       = 1'b0;
  assign init_done = r_init_done;

endmodule
